// File: rtl/gcd_pkg.sv
// Shared types and defaults for the fraction reducer and its GCD peer.
// State encoding is visible to the bench for cycle accounting.
package gcd_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DIVIDE
  } state_t;

endpackage

// File: rtl/fraction_reducer_if.sv
// User-side request bundle and the start/ready link to the GCD unit.
// master drives the request; slave answers it.
interface fraction_reducer_if
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         start;
  logic [W-1:0] num;
  logic [W-1:0] den;
  logic         ready;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic         err;

  modport master (
    output start, num, den,
    input  ready, out_num, out_den, err
  );
  modport slave (
    input  start, num, den,
    output ready, out_num, out_den, err
  );
endinterface

interface gcd_if
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         gcd_start;
  logic [W-1:0] gcd_a;
  logic [W-1:0] gcd_b;
  logic         gcd_ready;
  logic [W-1:0] gcd_out;

  modport master (
    output gcd_start, gcd_a, gcd_b,
    input  gcd_ready, gcd_out
  );
  modport slave (
    input  gcd_start, gcd_a, gcd_b,
    output gcd_ready, gcd_out
  );
endinterface

// File: rtl/sub_divider.sv
// Repeated-subtraction divider: one subtract per step until rem < divisor.
// Remainder doubles as the held operand before division starts.
module sub_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] value,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic [W-1:0] quot,
  output logic         done
);

  assign done = rem < divisor;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rem  <= '0;
      quot <= '0;
    end else if (load) begin
      rem  <= value;
      quot <= '0;
    end else if (step && !done) begin
      rem  <= rem - divisor;
      quot <= quot + 1'b1;
    end
  end

endmodule

// File: rtl/fraction_reducer.sv
// Reduces num/den to lowest terms using an external GCD unit,
// then divides both operands by the GCD with repeated subtraction.
module fraction_reducer
  import gcd_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  fraction_reducer_if.slave req,
  gcd_if.master             gcd
);

  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  g;
  logic [W-1:0]  out_num;
  logic [W-1:0]  out_den;
  logic          err;
  logic          load;
  logic          step;
  logic [W-1:0]  rn;
  logic [W-1:0]  rd;
  logic [W-1:0]  qn;
  logic [W-1:0]  qd;
  logic          done_n;
  logic          done_d;
  logic          den_zero;
  logic          num_zero;
  logic          timed_out;

  sub_divider #(.W(W)) u_div_n (
    .clk     (clk),
    .nrst    (nrst),
    .load    (load),
    .step    (step),
    .value   (req.num),
    .divisor (g),
    .rem     (rn),
    .quot    (qn),
    .done    (done_n)
  );

  sub_divider #(.W(W)) u_div_d (
    .clk     (clk),
    .nrst    (nrst),
    .load    (load),
    .step    (step),
    .value   (req.den),
    .divisor (g),
    .rem     (rd),
    .quot    (qd),
    .done    (done_d)
  );

  assign den_zero  = req.den == '0;
  assign num_zero  = req.num == '0;
  assign timed_out = cnt == CW'(TIMEOUT - 1);

  assign req.ready   = state == IDLE;
  assign req.out_num = out_num;
  assign req.out_den = out_den;
  assign req.err     = err;

  // Remainders hold the loaded operands stable until DIVIDE begins.
  assign gcd.gcd_a     = rn;
  assign gcd.gcd_b     = rd;
  assign gcd.gcd_start = (state == ISSUE) && gcd.gcd_ready;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req.start) begin
          load = 1'b1;
          if (!den_zero && !num_zero) state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (gcd.gcd_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (gcd.gcd_ready)  state_nx = DIVIDE;
        else if (timed_out) state_nx = IDLE;
      end
      DIVIDE: begin
        step = 1'b1;
        if (done_n && done_d) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      g       <= '0;
      out_num <= '0;
      out_den <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req.start) begin
            err <= den_zero;
            unique case (1'b1)
              den_zero: begin
                out_num <= '0;
                out_den <= '0;
              end
              num_zero: begin
                out_num <= '0;
                out_den <= W'(1);
              end
              default: ;
            endcase
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (gcd.gcd_ready) g <= gcd.gcd_out;
          else if (timed_out) err <= 1'b1;
        end
        DIVIDE: begin
          if (done_n && done_d) begin
            out_num <= qn;
            out_den <= qd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_reducer.sv
// Directed bench for fraction_reducer with a behavioural GCD peer
// (subtractive, one-step, or never-completing).
module tb_fraction_reducer;
  import gcd_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         nrst;
  int           tests;
  int           fails;
  int           starts;
  int           drops;
  int           div_cycles;
  int           mode;
  logic         hold;
  logic         m_ready;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_out;

  fraction_reducer_if #(.W(W)) req_if ();
  gcd_if #(.W(W)) g_if ();

  fraction_reducer #(.W(W), .TIMEOUT(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .req  (req_if),
    .gcd  (g_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  assign g_if.gcd_ready = m_ready & ~hold;
  assign g_if.gcd_out   = m_out;

  // mode 0: subtractive, 1: single busy cycle, 2: never completes
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_ready <= 1'b1;
      m_a     <= '0;
      m_b     <= '0;
      m_out   <= '0;
    end else if (g_if.gcd_start && g_if.gcd_ready) begin
      m_ready <= 1'b0;
      m_a <= (mode == 1) ? ref_gcd(g_if.gcd_a, g_if.gcd_b) : g_if.gcd_a;
      m_b <= (mode == 1) ? ref_gcd(g_if.gcd_a, g_if.gcd_b) : g_if.gcd_b;
    end else if (!m_ready && mode != 2) begin
      if (m_a > m_b) m_a <= m_a - m_b;
      else if (m_b > m_a) m_b <= m_b - m_a;
      else begin
        m_ready <= 1'b1;
        m_out   <= m_a;
      end
    end
  end

  always @(posedge clk) begin
    if (g_if.gcd_start === 1'b1) starts++;
    if (req_if.ready !== 1'b1) drops++;
    if (dut.state == DIVIDE) div_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [W-1:0] n, input logic [W-1:0] d);
    req_if.start = 1'b1;
    req_if.num   = n;
    req_if.den   = d;
    tick();
    req_if.start = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req_if.start = 1'b0;
    req_if.num = '0;
    req_if.den = '0;
    hold = 1'b0;
    mode = 0;
    #12;
    tests++;
    if (req_if.ready !== 1'b1 || req_if.out_num !== 8'd0 || req_if.out_den !== 8'd0
        || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b num=%0d den=%0d err=%b want 1 0 0 0",
               req_if.ready, req_if.out_num, req_if.out_den, req_if.err);
    end
    tests++;
    if (g_if.gcd_start !== 1'b0 || g_if.gcd_a !== 8'd0 || g_if.gcd_b !== 8'd0) begin
      fails++;
      $display("FAIL reset_gcd: start=%b a=%0d b=%0d want 0 0 0",
               g_if.gcd_start, g_if.gcd_a, g_if.gcd_b);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int k;
    mode = 0;
    div_cycles = 0;
    request(8'd12, 8'd18);
    tests++;
    if (req_if.ready !== 1'b0 || g_if.gcd_start !== 1'b1 || g_if.gcd_a !== 8'd12
        || g_if.gcd_b !== 8'd18) begin
      fails++;
      $display("FAIL basic_issue: ready=%b start=%b a=%0d b=%0d want 0 1 12 18",
               req_if.ready, g_if.gcd_start, g_if.gcd_a, g_if.gcd_b);
    end
    k = 0;
    while (req_if.ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (req_if.ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_done: ready=%b want 1", req_if.ready);
    end
    tests++;
    if (req_if.out_num !== 8'd2 || req_if.out_den !== 8'd3 || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: %0d/%0d err=%b want 2/3 err=0",
               req_if.out_num, req_if.out_den, req_if.err);
    end
    tests++;
    if (div_cycles != 4) begin
      fails++;
      $display("FAIL basic_div_cycles: got %0d want 4", div_cycles);
    end
  endtask

  task automatic test_equal_and_wide();
    int k;
    mode = 0;
    starts = 0;
    request(8'd7, 8'd7);
    k = 0;
    while (req_if.ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (starts != 1 || req_if.out_num !== 8'd1 || req_if.out_den !== 8'd1) begin
      fails++;
      $display("FAIL equal: starts=%0d result %0d/%0d want 1 pulse 1/1",
               starts, req_if.out_num, req_if.out_den);
    end
    mode = 1;
    div_cycles = 0;
    request(8'd255, 8'd1);
    k = 0;
    while (req_if.ready !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    tests++;
    if (req_if.out_num !== 8'd255 || req_if.out_den !== 8'd1 || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL wide_result: %0d/%0d err=%b want 255/1 err=0",
               req_if.out_num, req_if.out_den, req_if.err);
    end
    tests++;
    if (div_cycles != 256) begin
      fails++;
      $display("FAIL wide_div_cycles: got %0d want 256", div_cycles);
    end
  endtask

  task automatic test_zero_operands();
    mode = 0;
    starts = 0;
    drops = 0;
    request(8'd0, 8'd5);
    tests++;
    if (req_if.ready !== 1'b1 || req_if.out_num !== 8'd0 || req_if.out_den !== 8'd1
        || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL zero_num: ready=%b %0d/%0d err=%b want 1 0/1 0",
               req_if.ready, req_if.out_num, req_if.out_den, req_if.err);
    end
    tick();
    tick();
    request(8'd5, 8'd0);
    tests++;
    if (req_if.ready !== 1'b1 || req_if.out_num !== 8'd0 || req_if.out_den !== 8'd0
        || req_if.err !== 1'b1) begin
      fails++;
      $display("FAIL zero_den: ready=%b %0d/%0d err=%b want 1 0/0 1",
               req_if.ready, req_if.out_num, req_if.out_den, req_if.err);
    end
    tick();
    tests++;
    if (starts != 0 || drops != 0) begin
      fails++;
      $display("FAIL zero_quiet: gcd_starts=%0d ready_drops=%0d want 0 0", starts, drops);
    end
  endtask

  task automatic test_holdoff();
    int k;
    mode = 0;
    hold = 1'b1;
    starts = 0;
    request(8'd9, 8'd6);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (g_if.gcd_start !== 1'b0 || req_if.ready !== 1'b0 || g_if.gcd_a !== 8'd9) begin
        fails++;
        $display("FAIL holdoff_wait%0d: start=%b ready=%b a=%0d want 0 0 9",
                 i, g_if.gcd_start, req_if.ready, g_if.gcd_a);
      end
      if (i == 1) begin
        req_if.start = 1'b1;
        req_if.num   = 8'd50;
        req_if.den   = 8'd10;
      end
      tick();
      req_if.start = 1'b0;
    end
    hold = 1'b0;
    #1;
    tests++;
    if (g_if.gcd_start !== 1'b1 || g_if.gcd_a !== 8'd9 || g_if.gcd_b !== 8'd6) begin
      fails++;
      $display("FAIL holdoff_accept: start=%b a=%0d b=%0d want 1 9 6",
               g_if.gcd_start, g_if.gcd_a, g_if.gcd_b);
    end
    k = 0;
    while (req_if.ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (starts != 1 || req_if.out_num !== 8'd3 || req_if.out_den !== 8'd2
        || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL holdoff_result: starts=%0d %0d/%0d err=%b want 1 3/2 0",
               starts, req_if.out_num, req_if.out_den, req_if.err);
    end
  endtask

  task automatic test_timeout();
    mode = 2;
    request(8'd20, 8'd30);
    tick();
    repeat (7) tick();
    tests++;
    if (req_if.ready !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: ready=%b after 7 wait cycles want 0", req_if.ready);
    end
    tick();
    tests++;
    if (req_if.ready !== 1'b1 || req_if.err !== 1'b1 || req_if.out_num !== 8'd3
        || req_if.out_den !== 8'd2) begin
      fails++;
      $display("FAIL timeout_flag: ready=%b err=%b %0d/%0d want 1 1 3/2",
               req_if.ready, req_if.err, req_if.out_num, req_if.out_den);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    mode = 0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    request(8'd9, 8'd6);
    k = 0;
    while (req_if.ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    request(8'd100, 8'd75);
    k = 0;
    while (dut.state != DIVIDE && k < 50) begin
      tick();
      k++;
    end
    tick();
    tests++;
    if (req_if.ready !== 1'b0 || req_if.out_num !== 8'd3) begin
      fails++;
      $display("FAIL midreset_busy: ready=%b out_num=%0d want 0 3",
               req_if.ready, req_if.out_num);
    end
    nrst = 1'b0;
    #1;
    tests++;
    if (req_if.ready !== 1'b1 || req_if.out_num !== 8'd0 || req_if.out_den !== 8'd0
        || req_if.err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async: ready=%b %0d/%0d err=%b want 1 0/0 0",
               req_if.ready, req_if.out_num, req_if.out_den, req_if.err);
    end
    tick();
    nrst = 1'b1;
    tick();
    div_cycles = 0;
    request(8'd100, 8'd75);
    k = 0;
    while (req_if.ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tests++;
    if (req_if.out_num !== 8'd4 || req_if.out_den !== 8'd3 || req_if.err !== 1'b0
        || div_cycles != 5) begin
      fails++;
      $display("FAIL midreset_retry: %0d/%0d err=%b div=%0d want 4/3 0 5",
               req_if.out_num, req_if.out_den, req_if.err, div_cycles);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    starts = 0;
    drops = 0;
    div_cycles = 0;
    test_reset();
    test_basic();
    test_equal_and_wide();
    test_zero_operands();
    test_holdoff();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
